fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Owns the program counter and sequences instruction fetch for the core.
//  Issues one-outstanding fetch requests to instruction memory and holds each returned word in a
//  one-entry output buffer for decode.
//  Applies control-transfer redirects from execute, using the same cp_type next-PC rules as
//  the core's next-PC logic.
//  Sits between instruction memory and decode.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset; first fetch address after start
// PORTS
//  clk         in   1   system clock; all state updates on rising edge
//  rstn        in   1   reset, asynchronous assert, active-low
//  start       in   1   pulse: leave IDLE/HALTED and begin fetching at current pc
//  halt        in   1   pulse: stop fetching once outstanding request completes
//  imem_req    out  1   fetch request; held high until imem_ack
//  imem_addr   out  32  fetch address; stable while imem_req=1
//  imem_ack    in   1   memory accepts request and returns imem_data this cycle
//  imem_data   in   32  instruction word, valid with imem_ack
//  inst_valid  out  1   output buffer holds an instruction
//  inst        out  32  buffered instruction word
//  inst_pc     out  32  address that inst was fetched from
//  inst_ready  in   1   decode consumes inst when inst_valid&inst_ready
//  ctl_valid   in   1   redirect request, single-cycle
//  ctl_type    in   2   00 seq, 01 register (jr/ret), 10 jump (j/jal), 11 branch taken
//  ctl_pc      in   32  pc of the control instruction (base for the npc calculation)
//  ctl_regs    in   32  register target for type 01
//  ctl_immd    in   16  branch offset for type 11
//  ctl_addr    in   26  jump field for type 10
//  pc          out  32  next address to fetch
//  busy        out  1   state != IDLE and state != HALTED
// BEHAVIOUR
//  Reset (rstn=0, async):
//   state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=0,
//   inst_pc=0, drop=0, busy=0.
//  States: IDLE, RUN, HALTING, HALTED. All outputs registered.
//   IDLE/HALTED --start--> RUN.
//   RUN --halt--> HALTING.
//   HALTING --(no request outstanding)--> HALTED.
//   start while RUN/HALTING is ignored. halt in IDLE/HALTED is ignored.
//  Request issue: in RUN, imem_req rises at t+1 if, at cycle t, all of the following hold:
//   - no request is outstanding,
//   - no ack occurs at t,
//   - the buffer is empty or being consumed at t.
//   imem_addr=pc at issue. At most one request is outstanding.
//  Ack at t (no drop):
//   - inst<=imem_data, inst_pc<=imem_addr, inst_valid=1 at t+1;
//   - pc<=pc+4 (mod 2^32);
//   - imem_req=0 at t+1.
//   Minimum cadence with zero-wait memory: one instruction per 2 cycles.
//  Buffer: inst_valid clears at t+1 after a transfer at t unless refilled at t.
//   No refill while full, by the issue rule above.
//  Redirect (ctl_valid at t), npc computed from ctl_pc:
//   00: ctl_pc+4.  01: ctl_regs.  10: {ctl_pc[31:26],ctl_addr}.
//   11: ctl_pc+{16'b0,ctl_immd}. Zero-extended, no shift, 32-bit wrap.
//   - pc<=npc at t+1.
//   - inst_valid<=0 at t+1. A transfer completed at t stands.
//   - If a request is outstanding and not acked at t: it stays asserted with the old addr;
//     drop<=1; its ack data is discarded; drop clears on that ack.
//   - An ack coinciding with ctl_valid is discarded and pc takes npc, not pc+4.
//   - Fetch resumes from npc per the issue rule.
//   - Redirect in HALTING/HALTED/IDLE updates pc only.
//  Halt: the outstanding request completes and its word is buffered unless dropped.
//   The buffer stays valid until consumed. No new requests are issued.
//  Simultaneous halt and ctl_valid: both apply.
//  No alignment check: pc[1:0] is passed through unchanged.
// TESTING
//  - Reset, start at t0, imem_ack same cycle as req -> addrs 0,4,8 on req at t1,t3,t5;
//    inst_pc 0,4,8; inst_ready=1.
//  - inst_ready=0 for 5 cycles after first word -> imem_req stays 0, inst stable, pc=4;
//    on release, next req addr 4.
//  - ctl_valid type 11, ctl_pc=0x100, immd=0x0010, while req to 0x8 pending 3 cycles ->
//    ack data dropped, next req addr 0x110.
//  - Type 10, ctl_pc=0xFC00_0000, addr=0x3FF_FFFC -> next fetch 0xFFFF_FFFC.
//    Then seq fetch wraps to 0x0000_0000.
//  - ctl_valid coincident with ack -> no inst_valid, pc=npc. Type 01 regs=0x2000 -> req 0x2000.
//  - halt with req pending -> word buffered, HALTED, busy=0.
//    Then start -> resumes at next pc. rstn low mid-request -> all reset values immediately.

Source files
------------

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_sequencer
//  Description : Owns the program counter and issues single-outstanding
//                instruction fetches. Each returned word is held in a
//                one-entry buffer for decode. Control-transfer redirects
//                from execute are applied using the cp_type next-PC rules.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        ctl_valid,
    input  logic [1:0]  ctl_type,
    input  logic [31:0] ctl_pc,
    input  logic [31:0] ctl_regs,
    input  logic [15:0] ctl_immd,
    input  logic [25:0] ctl_addr,
    output logic [31:0] pc,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_HALTING = 2'd2,
        S_HALTED  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        drop_q, drop_d;
    logic        busy_q, busy_d;

    logic [31:0] w_npc;
    logic        w_ack;
    logic        w_consume;
    logic        w_stopped;
    logic        w_issue;
    logic        w_redir_run;
    logic        w_accept;

    // Redirect target from the control instruction's type and operands
    always_comb begin
        w_npc = ctl_pc + 32'd4;
        case (ctl_type)
            2'b00:   w_npc = ctl_pc + 32'd4;
            2'b01:   w_npc = ctl_regs;
            2'b10:   w_npc = {ctl_pc[31:26], ctl_addr};
            default: w_npc = ctl_pc + {16'b0, ctl_immd};
        endcase
    end

    // An ack only counts while our request is actually on the bus
    assign w_ack       = imem_ack & req_q;
    assign w_consume   = valid_q & inst_ready;
    assign w_stopped   = (state_q == S_IDLE) || (state_q == S_HALTED);
    // A start pulse issues the first fetch in the same cycle it is seen;
    // a halt pulse in RUN suppresses any further issue immediately.
    assign w_issue     = (((state_q == S_RUN) && !halt) || (w_stopped && start))
                         && !req_q && !imem_ack && (!valid_q || w_consume);
    // Pipeline-flushing effects of a redirect only apply while running;
    // otherwise a redirect just retargets the pc.
    assign w_redir_run = ctl_valid && (state_q == S_RUN);
    assign w_accept    = w_ack && !drop_q && !w_redir_run;

    // Next-state: control FSM, pc, request channel and output buffer
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_d     = req_q;
        addr_d    = addr_q;
        valid_d   = valid_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        drop_d    = drop_q;

        case (state_q)
            S_IDLE, S_HALTED: if (start) state_d = S_RUN;
            S_RUN:            if (halt)  state_d = S_HALTING;
            S_HALTING:        if (!req_q || w_ack) state_d = S_HALTED;
            default:          state_d = S_IDLE;
        endcase

        if (ctl_valid) begin
            pc_d = w_npc;
        end else if (w_ack && !drop_q) begin
            pc_d = pc_q + 32'd4;
        end

        // Issue uses the redirect target directly so a same-cycle redirect
        // never launches a wrong-path fetch.
        if (w_issue) begin
            req_d  = 1'b1;
            addr_d = ctl_valid ? w_npc : pc_q;
        end else if (w_ack) begin
            req_d  = 1'b0;
        end

        if (w_ack) begin
            drop_d = 1'b0;
        end else if (w_redir_run && req_q) begin
            drop_d = 1'b1;
        end

        if (w_redir_run) begin
            valid_d = 1'b0;
        end else if (w_accept) begin
            valid_d   = 1'b1;
            inst_d    = imem_data;
            inst_pc_d = addr_q;
        end else if (w_consume) begin
            valid_d = 1'b0;
        end

        busy_d = (state_d == S_RUN) || (state_d == S_HALTING);
    end

    // State registers, asynchronously cleared
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            req_q     <= 1'b0;
            addr_q    <= RESET_PC;
            valid_q   <= 1'b0;
            inst_q    <= 32'd0;
            inst_pc_q <= 32'd0;
            drop_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            req_q     <= req_d;
            addr_q    <= addr_d;
            valid_q   <= valid_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            drop_q    <= drop_d;
            busy_q    <= busy_d;
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign inst_valid = valid_q;
    assign inst       = inst_q;
    assign inst_pc    = inst_pc_q;
    assign pc         = pc_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_sequencer
//  Description : Directed self-checking bench for fetch_sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rstn, start, halt, imem_ack, inst_ready, ctl_valid;
    logic [31:0] imem_data, ctl_pc, ctl_regs;
    logic [1:0]  ctl_type;
    logic [15:0] ctl_immd;
    logic [25:0] ctl_addr;
    logic        imem_req, inst_valid, busy;
    logic [31:0] imem_addr, inst, inst_pc, pc;

    int n_checks = 0;
    int n_pass   = 0;
    logic auto_ack = 1'b0;

    localparam logic [31:0] C_KEY = 32'hDEAD_BEEF;

    fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rstn(rstn), .start(start), .halt(halt),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
        .inst_ready(inst_ready),
        .ctl_valid(ctl_valid), .ctl_type(ctl_type), .ctl_pc(ctl_pc),
        .ctl_regs(ctl_regs), .ctl_immd(ctl_immd), .ctl_addr(ctl_addr),
        .pc(pc), .busy(busy)
    );

    always #5 clk = ~clk;

    // Advance one clock; pulses drop, zero-wait memory answers when enabled
    task automatic cyc();
        @(posedge clk);
        #1;
        start     = 1'b0;
        halt      = 1'b0;
        ctl_valid = 1'b0;
        if (auto_ack) begin
            imem_ack  = imem_req;
            imem_data = imem_addr ^ C_KEY;
        end else begin
            imem_ack  = 1'b0;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; halt = 1'b0; imem_ack = 1'b0; imem_data = 32'd0;
        inst_ready = 1'b0; ctl_valid = 1'b0; ctl_type = 2'b00; ctl_pc = 32'd0;
        ctl_regs = 32'd0; ctl_immd = 16'd0; ctl_addr = 26'd0;
        cyc(); cyc();
        n_checks++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %h want 0", imem_req); else n_pass++;
        n_checks++; if (imem_addr !== 32'd0) $display("FAIL rst_addr: got %h want 0", imem_addr); else n_pass++;
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL rst_valid: got %h want 0", inst_valid); else n_pass++;
        n_checks++; if (pc !== 32'd0) $display("FAIL rst_pc: got %h want 0", pc); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %h want 0", busy); else n_pass++;
        rstn = 1'b1;
        cyc();
        n_checks++; if (imem_req !== 1'b0) $display("FAIL idle_req: got %h want 0", imem_req); else n_pass++;
    endtask

    task automatic test_sequential();
        inst_ready = 1'b1; auto_ack = 1'b1; start = 1'b1;
        cyc();  // t1
        n_checks++; if (busy !== 1'b1) $display("FAIL seq_busy: got %h want 1", busy); else n_pass++;
        n_checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) $display("FAIL seq_req0: got %h/%h want 1/00000000", imem_req, imem_addr); else n_pass++;
        cyc();  // t2
        n_checks++; if ({inst_valid, inst_pc} !== {1'b1, 32'h0}) $display("FAIL seq_buf0: got %h/%h want 1/00000000", inst_valid, inst_pc); else n_pass++;
        n_checks++; if (inst !== 32'hDEAD_BEEF) $display("FAIL seq_inst0: got %h want deadbeef", inst); else n_pass++;
        n_checks++; if ({imem_req, pc} !== {1'b0, 32'h4}) $display("FAIL seq_pc4: got %h/%h want 0/00000004", imem_req, pc); else n_pass++;
        cyc();  // t3
        n_checks++; if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'h4, 1'b0}) $display("FAIL seq_req4: got %h/%h/%h want 1/00000004/0", imem_req, imem_addr, inst_valid); else n_pass++;
        cyc();  // t4
        n_checks++; if ({inst_valid, inst_pc} !== {1'b1, 32'h4}) $display("FAIL seq_buf4: got %h/%h want 1/00000004", inst_valid, inst_pc); else n_pass++;
        cyc();  // t5
        n_checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h8}) $display("FAIL seq_req8: got %h/%h want 1/00000008", imem_req, imem_addr); else n_pass++;
        cyc();  // t6
        n_checks++; if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h8, 32'hDEAD_BEE7}) $display("FAIL seq_buf8: got %h/%h/%h want 1/00000008/deadbee7", inst_valid, inst_pc, inst); else n_pass++;
        n_checks++; if (pc !== 32'hC) $display("FAIL seq_pc12: got %h want 0000000c", pc); else n_pass++;
    endtask

    task automatic test_stall();
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_checks++; if ({imem_req, inst_valid, inst_pc, pc} !== {1'b0, 1'b1, 32'h8, 32'hC}) $display("FAIL stall_%0d: got req=%h v=%h ipc=%h pc=%h want 0/1/00000008/0000000c", i, imem_req, inst_valid, inst_pc, pc); else n_pass++;
        end
        inst_ready = 1'b1; auto_ack = 1'b0;
        cyc();
        n_checks++; if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'hC, 1'b0}) $display("FAIL stall_release: got %h/%h/%h want 1/0000000c/0", imem_req, imem_addr, inst_valid); else n_pass++;
    endtask

    task automatic test_redirect_drop();
        ctl_valid = 1'b1; ctl_type = 2'b11; ctl_pc = 32'h100; ctl_immd = 16'h0010;
        cyc();
        n_checks++; if (pc !== 32'h110) $display("FAIL br_pc: got %h want 00000110", pc); else n_pass++;
        n_checks++; if ({imem_req, imem_addr} !== {1'b1, 32'hC}) $display("FAIL br_hold: got %h/%h want 1/0000000c", imem_req, imem_addr); else n_pass++;
        cyc();
        n_checks++; if ({imem_req, imem_addr} !== {1'b1, 32'hC}) $display("FAIL br_hold2: got %h/%h want 1/0000000c", imem_req, imem_addr); else n_pass++;
        imem_ack = 1'b1; imem_data = 32'h1111_1111;
        cyc();
        n_checks++; if ({imem_req, inst_valid, pc} !== {1'b0, 1'b0, 32'h110}) $display("FAIL br_drop: got %h/%h/%h want 0/0/00000110", imem_req, inst_valid, pc); else n_pass++;
        auto_ack = 1'b1;
        cyc();
        n_checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h110}) $display("FAIL br_req: got %h/%h want 1/00000110", imem_req, imem_addr); else n_pass++;
    endtask

    task automatic test_jump_wrap();
        cyc();
        n_checks++; if ({inst_valid, inst_pc, pc} !== {1'b1, 32'h110, 32'h114}) $display("FAIL j_buf: got %h/%h/%h want 1/00000110/00000114", inst_valid, inst_pc, pc); else n_pass++;
        ctl_valid = 1'b1; ctl_type = 2'b10; ctl_pc = 32'hFC00_0000; ctl_addr = 26'h3FF_FFFC;
        cyc();
        n_checks++; if ({imem_req, imem_addr, inst_valid} !== {1'b1, 32'hFFFF_FFFC, 1'b0}) $display("FAIL j_req: got %h/%h/%h want 1/fffffffc/0", imem_req, imem_addr, inst_valid); else n_pass++;
        cyc();
        n_checks++; if ({inst_valid, inst_pc, pc} !== {1'b1, 32'hFFFF_FFFC, 32'h0}) $display("FAIL j_wrap: got %h/%h/%h want 1/fffffffc/00000000", inst_valid, inst_pc, pc); else n_pass++;
        cyc();
        n_checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) $display("FAIL j_req0: got %h/%h want 1/00000000", imem_req, imem_addr); else n_pass++;
    endtask

    task automatic test_ack_redirect();
        ctl_valid = 1'b1; ctl_type = 2'b01; ctl_regs = 32'h2000;
        cyc();
        n_checks++; if ({inst_valid, imem_req, pc} !== {1'b0, 1'b0, 32'h2000}) $display("FAIL ar_flush: got %h/%h/%h want 0/0/00002000", inst_valid, imem_req, pc); else n_pass++;
        cyc();
        n_checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h2000}) $display("FAIL ar_req: got %h/%h want 1/00002000", imem_req, imem_addr); else n_pass++;
        cyc();
        n_checks++; if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h2000, 32'hDEAD_9EEF}) $display("FAIL ar_buf: got %h/%h/%h want 1/00002000/dead9eef", inst_valid, inst_pc, inst); else n_pass++;
        auto_ack = 1'b0;
    endtask

    task automatic test_halt();
        cyc();
        n_checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h2004}) $display("FAIL h_req: got %h/%h want 1/00002004", imem_req, imem_addr); else n_pass++;
        halt = 1'b1;
        cyc();
        n_checks++; if ({busy, imem_req} !== {1'b1, 1'b1}) $display("FAIL h_halting: got %h/%h want 1/1", busy, imem_req); else n_pass++;
        imem_ack = 1'b1; imem_data = 32'hCAFE_F00D; inst_ready = 1'b0;
        cyc();
        n_checks++; if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h2004, 32'hCAFE_F00D}) $display("FAIL h_buf: got %h/%h/%h want 1/00002004/cafef00d", inst_valid, inst_pc, inst); else n_pass++;
        n_checks++; if ({imem_req, busy, pc} !== {1'b0, 1'b0, 32'h2008}) $display("FAIL h_halted: got %h/%h/%h want 0/0/00002008", imem_req, busy, pc); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_checks++; if ({imem_req, inst_valid} !== {1'b0, 1'b1}) $display("FAIL h_idle_%0d: got %h/%h want 0/1", i, imem_req, inst_valid); else n_pass++;
        end
        ctl_valid = 1'b1; ctl_type = 2'b00; ctl_pc = 32'h300;
        cyc();
        n_checks++; if ({pc, inst_valid, imem_req} !== {32'h304, 1'b1, 1'b0}) $display("FAIL h_redir: got %h/%h/%h want 00000304/1/0", pc, inst_valid, imem_req); else n_pass++;
        inst_ready = 1'b1;
        cyc();
        n_checks++; if ({inst_valid, imem_req} !== {1'b0, 1'b0}) $display("FAIL h_drain: got %h/%h want 0/0", inst_valid, imem_req); else n_pass++;
        start = 1'b1;
        cyc();
        n_checks++; if ({imem_req, imem_addr, busy} !== {1'b1, 32'h304, 1'b1}) $display("FAIL h_restart: got %h/%h/%h want 1/00000304/1", imem_req, imem_addr, busy); else n_pass++;
    endtask

    task automatic test_reset_mid();
        #2;
        rstn = 1'b0;
        #1;
        n_checks++; if ({imem_req, imem_addr, inst_valid, pc, busy} !== {1'b0, 32'h0, 1'b0, 32'h0, 1'b0}) $display("FAIL async_rst: got %h/%h/%h/%h/%h want 0/00000000/0/00000000/0", imem_req, imem_addr, inst_valid, pc, busy); else n_pass++;
        n_checks++; if ({inst, inst_pc} !== {32'h0, 32'h0}) $display("FAIL async_rst_buf: got %h/%h want 00000000/00000000", inst, inst_pc); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_drop();
        test_jump_wrap();
        test_ack_redirect();
        test_halt();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
